// File: rtl/fpnew_divsqrt_arbiter_pkg.sv
// Shared helpers for the div/sqrt arbiter slice.
package fpnew_divsqrt_arbiter_pkg;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_arb_id_fifo.sv
// In-order queue of requester IDs for operations accepted by the shared unit.
module fpnew_arb_id_fifo
  import fpnew_divsqrt_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Round-robin sharing of one multi-cycle div/sqrt unit between NumReq requesters,
// with in-order routing of responses back through a requester-ID queue.
module fpnew_divsqrt_arbiter
  import fpnew_divsqrt_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxInFlight = 2,
  parameter type         ReqType     = logic,
  parameter type         RspType     = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic   [NumReq-1:0]        req_valid_i,
  output logic   [NumReq-1:0]        req_ready_o,
  input  ReqType [NumReq-1:0]        req_data_i,
  output logic                       unit_valid_o,
  input  logic                       unit_ready_i,
  output ReqType                     unit_data_o,
  input  logic                       unit_valid_i,
  output logic                       unit_ready_o,
  input  RspType                     unit_data_i,
  output logic   [NumReq-1:0]        rsp_valid_o,
  input  logic   [NumReq-1:0]        rsp_ready_i,
  output RspType                     rsp_data_o,
  input  logic                       flush_i,
  output logic                       busy_o
);
  localparam int unsigned IdW = idx_width(NumReq);
  localparam logic [IdW-1:0] LastId = IdW'(NumReq - 1);

  logic [IdW-1:0] rr_q, rr_d, lock_id_q, lock_id_d, rr_gnt, gnt, head_id;
  logic           lock_q, lock_d;
  logic           id_full, id_empty, handshake, pop;

  fpnew_arb_id_fifo #(
    .Depth (MaxInFlight),
    .Width (IdW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (handshake),
    .data_i  (gnt),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

  always_comb begin
    int unsigned idx;
    idx    = 0;
    rr_gnt = rr_q;
    for (int unsigned i = NumReq; i > 0; i--) begin
      idx = (int'(rr_q) + i - 1) % NumReq;
      if (req_valid_i[idx]) rr_gnt = IdW'(idx);
    end
  end

  // A stalled grant is pinned so the payload seen by the unit cannot change.
  assign gnt          = lock_q ? lock_id_q : rr_gnt;
  assign unit_valid_o = req_valid_i[gnt] & ~id_full & ~flush_i & ~rst_i;
  assign unit_data_o  = req_data_i[gnt];
  assign handshake    = unit_valid_o & unit_ready_i;
  assign unit_ready_o = ~id_empty & rsp_ready_i[head_id];
  assign pop          = unit_valid_i & unit_ready_o;
  assign rsp_data_o   = unit_data_i;
  assign busy_o       = ~id_empty | lock_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    rr_d      = rr_q;
    lock_d    = unit_valid_o & ~unit_ready_i;
    lock_id_d = gnt;
    if (handshake) rr_d = (gnt == LastId) ? '0 : gnt + 1'b1;
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (handshake) req_ready_o[gnt] = 1'b1;
    if (!id_empty && unit_valid_i && !flush_i && !rst_i) rsp_valid_o[head_id] = 1'b1;
  end

  a_no_rsp_when_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    !(unit_valid_i && id_empty));

endmodule
